// File: rtl/left_normalizer_lzc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : left_normalizer_lzc_seq_if
// Description : Handshake and data bundle for the iterative left normalizer.
//               The master drives the input significand and valid, and
//               drives the result-side ready. The slave (the normalizer)
//               returns input-side ready and the normalized result.
//   i_in        [N-2:0]           significand to normalize
//   i_valid                       i_in valid
//   o_in_ready                    normalizer can accept i_in
//   o_r         [N-2:0]           normalized significand
//   o_count     [$clog2(N)-1:0]   left-shift amount (leading-zero count)
//   o_zero                        captured input was all zeros
//   o_valid                       result fields valid
//   i_out_ready                   downstream accepts result
// Revision    : 1.0 - initial release
// ============================================================================
interface left_normalizer_lzc_seq_if #(
  parameter int N = 16
) ();
  logic [N-2:0]         i_in;
  logic                 i_valid;
  logic                 o_in_ready;
  logic [N-2:0]         o_r;
  logic [$clog2(N)-1:0] o_count;
  logic                 o_zero;
  logic                 o_valid;
  logic                 i_out_ready;

  modport master (
    output i_in, i_valid, i_out_ready,
    input  o_in_ready, o_r, o_count, o_zero, o_valid
  );

  modport slave (
    input  i_in, i_valid, i_out_ready,
    output o_in_ready, o_r, o_count, o_zero, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/left_normalizer_lzc_seq.sv
`default_nettype none
// ============================================================================
// Module      : left_normalizer_lzc_seq
// Description : Iterative post-add normalizer. Counts the leading zeros of an
//               (N-1)-bit significand and left-shifts it until its MSB is 1,
//               using one binary shift stage (2^k positions, k = STAGES-1..0)
//               per clock. valid/ready handshake on both sides; one operation
//               in flight at a time.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - asynchronous reset, active-high
//               bus    - slave side of left_normalizer_lzc_seq_if (input
//                        significand/valid/ready, result/count/zero/valid,
//                        downstream ready)
// Options     : NORM_BYPASS_EN - inputs whose MSB is already set complete
//               after a single cycle instead of STAGES cycles. Results are
//               identical either way; only latency differs.
// Revision    : 1.0 - initial release
// ============================================================================
module left_normalizer_lzc_seq #(
  parameter int N = 16
) (
  input  wire logic                 i_clk,
  input  wire logic                 i_rst,
  left_normalizer_lzc_seq_if.slave  bus
);

  localparam int W      = N - 1;
  localparam int STAGES = $clog2(N);
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      work_q, work_d;
  logic [STAGES-1:0] count_q, count_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic              in_zero_q, in_zero_d;
  logic [W-1:0]      r_q, r_d;
  logic [STAGES-1:0] cnt_out_q, cnt_out_d;
  logic              zero_out_q, zero_out_d;
  logic              valid_q, valid_d;

  logic              in_ready_w;
  logic [W-1:0]      shift_work_w;
  logic [STAGES-1:0] shift_count_w;

  // Per-stage precomputation: is the top 2^s-bit window zero, and the
  // work value shifted by 2^s. Only the stage selected by stage_q is used.
  logic [STAGES-1:0] top_zero_w;
  logic [W-1:0]      shifted_w [STAGES];

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      assign top_zero_w[s] = (work_q[W-1 -: (1 << s)] == '0);
      assign shifted_w[s]  = work_q << (1 << s);
    end
  endgenerate

  // Held low during reset so nothing is accepted while flops are cleared.
  assign in_ready_w = (state_q == IDLE) && !i_rst;

  always_comb begin
    shift_work_w  = work_q;
    shift_count_w = count_q;
    for (int s = 0; s < STAGES; s++) begin
      if (stage_q == SW'(s) && top_zero_w[s]) begin
        shift_work_w     = shifted_w[s];
        shift_count_w[s] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    count_d    = count_q;
    stage_d    = stage_q;
    in_zero_d  = in_zero_q;
    r_d        = r_q;
    cnt_out_d  = cnt_out_q;
    zero_out_d = zero_out_q;
    valid_d    = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.i_valid && in_ready_w) begin
          work_d    = bus.i_in;
          count_d   = '0;
          stage_d   = SW'(STAGES - 1);
          in_zero_d = (bus.i_in == '0);
          state_d   = SHIFT;
`ifdef NORM_BYPASS_EN
          // MSB already set: start at stage 0, which cannot shift (its
          // one-bit window is the set MSB), so DONE follows in one cycle.
          if (bus.i_in[W-1]) begin
            stage_d = '0;
          end
`endif
        end
      end

      SHIFT: begin
        work_d  = shift_work_w;
        count_d = shift_count_w;
        if (stage_q == '0) begin
          // Result registers take the post-shift value of the final stage.
          state_d    = DONE;
          r_d        = shift_work_w;
          cnt_out_d  = shift_count_w;
          zero_out_d = in_zero_q;
          valid_d    = 1'b1;
        end else begin
          stage_d = stage_q - 1'b1;
        end
      end

      DONE: begin
        if (bus.i_out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      count_q    <= '0;
      stage_q    <= '0;
      in_zero_q  <= 1'b0;
      r_q        <= '0;
      cnt_out_q  <= '0;
      zero_out_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      count_q    <= count_d;
      stage_q    <= stage_d;
      in_zero_q  <= in_zero_d;
      r_q        <= r_d;
      cnt_out_q  <= cnt_out_d;
      zero_out_q <= zero_out_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.o_in_ready = in_ready_w;
  assign bus.o_r        = r_q;
  assign bus.o_count    = cnt_out_q;
  assign bus.o_zero     = zero_out_q;
  assign bus.o_valid    = valid_q;

endmodule
`default_nettype wire
